// File: rtl/tx_shaper_pkg.sv
// Shared constants for the 4x oversampled RRC transmit pulse shaper:
// polyphase geometry, symbol codes and the 16-tap coefficient set.
package tx_shaper_pkg;

  localparam int unsigned OSR        = 4;
  localparam int unsigned SPAN       = 4;
  localparam int unsigned NTAPS      = OSR * SPAN;
  localparam int unsigned IDX_W      = $clog2(NTAPS);
  localparam int unsigned PHASE_W    = $clog2(OSR);
  localparam int unsigned SYM_W      = 2;
  localparam int unsigned PKG_COEF_W = 8;

  typedef logic signed [SYM_W-1:0]      sym_t;
  typedef logic signed [PKG_COEF_W-1:0] coef_t;

  localparam sym_t SYM_ZERO = 2'b00;
  localparam sym_t SYM_POS1 = 2'b01;
  localparam sym_t SYM_NEG1 = 2'b11;
  localparam sym_t SYM_NEG2 = 2'b10;

  // Root-raised-cosine, roll-off 0.35, symmetric, peak 127 at taps 7 and 8
  localparam coef_t COEF [NTAPS] = '{
    -8'sd2,  -8'sd6,  -8'sd8,  -8'sd2,
     8'sd14,  8'sd42,  8'sd84,  8'sd127,
     8'sd127, 8'sd84,  8'sd42,  8'sd14,
    -8'sd2,  -8'sd8,  -8'sd6,  -8'sd2
  };

endpackage

// File: rtl/tx_pulse_shaper_rail.sv
// One rail of the pulse shaper: 4-deep symbol delay line and polyphase
// multiply-accumulate, with a registered sample output.
module shaper_rail
  import tx_shaper_pkg::*;
#(
  parameter int unsigned COEF_W = 8,
  parameter int unsigned OUT_W  = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_shift,
  input  logic [SYM_W-1:0]         i_sym,
  input  logic [PHASE_W-1:0]       i_phase,
  input  logic                     i_out_en,
  output logic signed [OUT_W-1:0]  o_shaped
);

  // Product of a coefficient and a 2-bit symbol plus growth for four taps
  localparam int unsigned ACC_W = COEF_W + SYM_W + 2;

  sym_t                    r_sym  [SPAN];
  logic signed [ACC_W-1:0] w_prod [SPAN];
  logic signed [ACC_W-1:0] w_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SPAN; k++) r_sym[k] <= '0;
    end else if (i_shift) begin
      r_sym[0] <= i_sym;
      for (int k = 1; k < SPAN; k++) r_sym[k] <= r_sym[k-1];
    end
  end

  // Tap k at phase p uses coefficient 4k+p, i.e. {k, p} as the index
  for (genvar k = 0; k < SPAN; k++) begin : g_tap
    logic [IDX_W-1:0] w_idx;
    assign w_idx     = {(IDX_W-PHASE_W)'(k), i_phase};
    assign w_prod[k] = ACC_W'(r_sym[k]) * ACC_W'(COEF[w_idx]);
  end

  always_comb begin
    w_acc = '0;
    for (int k = 0; k < SPAN; k++) w_acc = w_acc + w_prod[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        o_shaped <= '0;
    else if (i_out_en) o_shaped <= OUT_W'(w_acc);
  end

endmodule

// File: rtl/tx_pulse_shaper.sv
// 4x oversampling RRC pulse shaper for I/Q symbols with late-strobe detection.
// Optional SHAPER_FLUSH_EN: zero symbols are shifted in while stalled.
module tx_pulse_shaper
  import tx_shaper_pkg::*;
#(
  parameter int unsigned COEF_W = 8,
  parameter int unsigned OUT_W  = 10
) (
  input  logic                     clk_4megahz,
  input  logic                     rst_n,
  input  logic                     sym_en,
  input  logic [SYM_W-1:0]         diff_remapped_i,
  input  logic [SYM_W-1:0]         diff_remapped_q,
  output logic signed [OUT_W-1:0]  shaped_i,
  output logic signed [OUT_W-1:0]  shaped_q,
  output logic                     out_valid,
  output logic                     underrun
);

  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(OSR - 1);

  logic [PHASE_W-1:0] r_phase;
  logic               r_active;
  logic               w_late;
  logic               w_flush;
  logic               w_shift;
  logic [SYM_W-1:0]   w_sym_i;
  logic [SYM_W-1:0]   w_sym_q;

  // Phase 3 passed without a strobe; only meaningful once symbols have started
  assign w_late = r_active & ~sym_en & (r_phase == PHASE_LAST);

`ifdef SHAPER_FLUSH_EN
  localparam int unsigned FLUSH_W = $clog2(SPAN) + 1;

  logic [FLUSH_W-1:0] r_flush_cnt;

  assign w_flush = w_late & (r_flush_cnt < FLUSH_W'(SPAN));

  always_ff @(posedge clk_4megahz or negedge rst_n) begin
    if (!rst_n)       r_flush_cnt <= '0;
    else if (sym_en)  r_flush_cnt <= '0;
    else if (w_flush) r_flush_cnt <= r_flush_cnt + 1'b1;
  end
`else
  assign w_flush = 1'b0;
`endif

  assign w_shift = sym_en | w_flush;
  assign w_sym_i = sym_en ? diff_remapped_i : SYM_ZERO;
  assign w_sym_q = sym_en ? diff_remapped_q : SYM_ZERO;

  always_ff @(posedge clk_4megahz or negedge rst_n) begin
    if (!rst_n) begin
      r_phase   <= '0;
      r_active  <= 1'b0;
      out_valid <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      if (sym_en) r_active <= 1'b1;
      out_valid <= out_valid | r_active;
      if (w_late) underrun <= 1'b1;
      // A strobe (early or on time) or a flush shift restarts the phase
      if (w_shift)
        r_phase <= '0;
      else if (r_active && (r_phase != PHASE_LAST))
        r_phase <= r_phase + 1'b1;
    end
  end

  shaper_rail #(
    .COEF_W (COEF_W),
    .OUT_W  (OUT_W)
  ) u_rail_i (
    .clk      (clk_4megahz),
    .rst_n    (rst_n),
    .i_shift  (w_shift),
    .i_sym    (w_sym_i),
    .i_phase  (r_phase),
    .i_out_en (r_active),
    .o_shaped (shaped_i)
  );

  shaper_rail #(
    .COEF_W (COEF_W),
    .OUT_W  (OUT_W)
  ) u_rail_q (
    .clk      (clk_4megahz),
    .rst_n    (rst_n),
    .i_shift  (w_shift),
    .i_sym    (w_sym_q),
    .i_phase  (r_phase),
    .i_out_en (r_active),
    .o_shaped (shaped_q)
  );

endmodule

// File: tb/tb_tx_pulse_shaper.sv
// Self-checking bench for tx_pulse_shaper: table of nominal-rate symbols checked
// through a scoreboard, plus early, late/stall and mid-symbol reset sequences.
module tb_tx_pulse_shaper;
  import tx_shaper_pkg::*;

  localparam int unsigned COEF_W = 8;
  localparam int unsigned OUT_W  = 10;
  localparam int          NV     = 23;
  localparam int          TC [16] = '{-2, -6, -8, -2, 14, 42, 84, 127,
                                      127, 84, 42, 14, -2, -8, -6, -2};

  logic                    clk_4megahz = 1'b0;
  logic                    rst_n;
  logic                    sym_en;
  logic [1:0]              diff_remapped_i;
  logic [1:0]              diff_remapped_q;
  logic signed [OUT_W-1:0] shaped_i;
  logic signed [OUT_W-1:0] shaped_q;
  logic                    out_valid;
  logic                    underrun;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct packed { int due; int ei; int eq; } exp_t;
  exp_t sb[$];

  typedef struct packed {
    logic [1:0]       si;
    logic [1:0]       sq;
    logic [3:0][15:0] ei;
    logic [3:0][15:0] eq;
  } vec_t;
  vec_t vecs [NV];

  tx_pulse_shaper #(
    .COEF_W (COEF_W),
    .OUT_W  (OUT_W)
  ) dut (
    .clk_4megahz     (clk_4megahz),
    .rst_n           (rst_n),
    .sym_en          (sym_en),
    .diff_remapped_i (diff_remapped_i),
    .diff_remapped_q (diff_remapped_q),
    .shaped_i        (shaped_i),
    .shaped_q        (shaped_q),
    .out_valid       (out_valid),
    .underrun        (underrun)
  );

  always #5 clk_4megahz = ~clk_4megahz;

  function automatic int dec(input logic [1:0] c);
    case (c)
      2'b01:   return 1;
      2'b11:   return -1;
      2'b10:   return -2;
      default: return 0;
    endcase
  endfunction

  function automatic int conv(input int h0, input int h1, input int h2, input int h3, input int p);
    return h0 * TC[p] + h1 * TC[4+p] + h2 * TC[8+p] + h3 * TC[12+p];
  endfunction

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance one cycle; compare due scoreboard entries, then drive this cycle's inputs
  task automatic tick(input logic en, input logic [1:0] si, input logic [1:0] sq);
    exp_t e;
    @(posedge clk_4megahz);
    #1;
    cyc++;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      check($sformatf("sb_i@%0d", e.due), shaped_i, e.ei);
      check($sformatf("sb_q@%0d", e.due), shaped_q, e.eq);
      check($sformatf("sb_valid@%0d", e.due), out_valid, 1);
    end
    sym_en          = en;
    diff_remapped_i = si;
    diff_remapped_q = sq;
  endtask

  task automatic do_reset();
    @(negedge clk_4megahz);
    rst_n  = 1'b0;
    sym_en = 1'b0;
    @(negedge clk_4megahz);
    rst_n  = 1'b1;
  endtask

  function automatic int late_exp(input int n);
`ifdef SHAPER_FLUSH_EN
    return (n <= 17) ? TC[n-2] : 0;
`else
    return (n <= 5) ? TC[n-2] : TC[3];
`endif
  endfunction

  initial begin
    int hi [4];
    int hq [4];
    logic [1:0] si;
    logic [1:0] sq;
    int c;
    int e;

    rst_n = 1'b0;
    sym_en = 1'b0;
    diff_remapped_i = 2'b00;
    diff_remapped_q = 2'b00;

    // Table: impulse, constant +1, alternating full scale, -2 code, then zeros
    for (int k = 0; k < 4; k++) begin hi[k] = 0; hq[k] = 0; end
    for (int j = 0; j < NV; j++) begin
      if (j == 0)                    begin si = SYM_POS1; sq = SYM_NEG1; end
      else if (j <= 4)               begin si = SYM_ZERO; sq = SYM_ZERO; end
      else if (j <= 10)              begin si = SYM_POS1; sq = SYM_POS1; end
      else if (j <= 16)              begin si = (j % 2 == 1) ? SYM_POS1 : SYM_NEG1;
                                           sq = (j % 2 == 1) ? SYM_NEG1 : SYM_POS1; end
      else if (j == 17)              begin si = SYM_NEG2; sq = SYM_POS1; end
      else if (j == 18)              begin si = SYM_NEG2; sq = SYM_NEG1; end
      else                           begin si = SYM_ZERO; sq = SYM_ZERO; end
      for (int k = 3; k > 0; k--) begin hi[k] = hi[k-1]; hq[k] = hq[k-1]; end
      hi[0] = dec(si);
      hq[0] = dec(sq);
      vecs[j].si = si;
      vecs[j].sq = sq;
      for (int p = 0; p < 4; p++) begin
        vecs[j].ei[p] = 16'(conv(hi[0], hi[1], hi[2], hi[3], p));
        vecs[j].eq[p] = 16'(conv(hq[0], hq[1], hq[2], hq[3], p));
      end
    end

    // Reset state
    repeat (2) @(posedge clk_4megahz);
    #1;
    check("rst_shaped_i", shaped_i, 0);
    check("rst_shaped_q", shaped_q, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_underrun", underrun, 0);
    @(negedge clk_4megahz);
    rst_n = 1'b1;

    // Nominal rate: one strobe every 4 cycles, sample p of a symbol due 2+p cycles later
    for (int j = 0; j < NV; j++) begin
      tick(1'b1, vecs[j].si, vecs[j].sq);
      for (int p = 0; p < 4; p++)
        sb.push_back('{due: cyc + 2 + p,
                       ei: int'($signed(vecs[j].ei[p])),
                       eq: int'($signed(vecs[j].eq[p]))});
      repeat (3) tick(1'b0, 2'b00, 2'b00);
    end
    check("table_underrun", underrun, 0);
    repeat (2) tick(1'b0, 2'b00, 2'b00);
    check("sb_drain", sb.size(), 0);

    // Early strobe at phase 1
    do_reset();
    tick(1'b1, 2'b01, 2'b01);
    c = cyc;
    tick(1'b0, 2'b00, 2'b00);
    tick(1'b1, 2'b01, 2'b01);
    check("early_c2", shaped_i, TC[0]);
    tick(1'b0, 2'b00, 2'b00);
    check("early_c3", shaped_i, TC[1]);
    check("early_ur_c3", underrun, 0);
    tick(1'b0, 2'b00, 2'b00);
    check("early_restart_p0", shaped_i, TC[0] + TC[4]);
    tick(1'b0, 2'b00, 2'b00);
    check("early_restart_p1", shaped_i, TC[1] + TC[5]);
    tick(1'b1, 2'b00, 2'b00);
    check("early_restart_p2", shaped_q, TC[2] + TC[6]);
    tick(1'b0, 2'b00, 2'b00);
    check("early_restart_p3", shaped_i, TC[3] + TC[7]);
    check("early_ur_end", underrun, 0);
    check("early_cycles", cyc - c, 7);

    // Late strobe: stall after one symbol
    do_reset();
    tick(1'b1, 2'b01, 2'b11);
    for (int n = 1; n <= 20; n++) begin
      tick(1'b0, 2'b00, 2'b00);
      if (n >= 2) begin
        e = late_exp(n);
        check($sformatf("late_i_n%0d", n), shaped_i, e);
        check($sformatf("late_q_n%0d", n), shaped_q, -e);
        check($sformatf("late_ur_n%0d", n), underrun, (n >= 5) ? 1 : 0);
      end
    end
    tick(1'b1, 2'b11, 2'b01);
    tick(1'b0, 2'b00, 2'b00);
    tick(1'b0, 2'b00, 2'b00);
`ifdef SHAPER_FLUSH_EN
    check("resume_i", shaped_i, -TC[0]);
    check("resume_q", shaped_q, TC[0]);
`else
    check("resume_i", shaped_i, TC[4] - TC[0]);
    check("resume_q", shaped_q, TC[0] - TC[4]);
`endif
    check("resume_ur_sticky", underrun, 1);
    check("resume_valid", out_valid, 1);

    // Reset pulsed mid-symbol clears everything without waiting for an edge
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_shaped_i", shaped_i, 0);
    check("arst_shaped_q", shaped_q, 0);
    check("arst_out_valid", out_valid, 0);
    check("arst_underrun", underrun, 0);
    @(negedge clk_4megahz);
    rst_n = 1'b1;
    tick(1'b1, 2'b01, 2'b11);
    check("post_rst_valid_c0", out_valid, 0);
    tick(1'b0, 2'b00, 2'b00);
    check("post_rst_valid_c1", out_valid, 0);
    tick(1'b0, 2'b00, 2'b00);
    check("post_rst_valid_c2", out_valid, 1);
    check("post_rst_i_c2", shaped_i, TC[0]);
    check("post_rst_q_c2", shaped_q, -TC[0]);
    check("post_rst_ur_c2", underrun, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation ran past time limit, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
